// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl
//   APB-attached driver for a time-multiplexed seven-segment display bank.
//   Holds six hex digits and a control word and scans the digits one at a
//   time. Each slot is PRESCALE clocks: PRESCALE-DEADTIME clocks lit,
//   then DEADTIME clocks fully dark so the previous digit cannot ghost
//   into the next one.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   S_PSELx ..      APB slave (zero wait state, 2-bit word address)
//   S_PRDATA        read data, combinational in the access phase, else 0
//   S_PREADY        PSEL & PENABLE
//   seg[6:0]        segments {g,f,e,d,c,b,a}, active-low when INVERT=1
//   an[NDIGITS-1:0] one-hot digit select, active-low when INVERT=1
//
// Register map (word address)
//   0 DATA_LO  digits 3..0 (digit 0 in [3:0])
//   1 DATA_HI  digits 5..4 in [7:0]
//   2 CTRL     [5:0] digit enable mask, [8] scan enable
//   3 STATUS   [2:0] digit index, [4:3] state (0 idle, 1 show, 2 blank), RO
module ssd_scan_ctrl #(
    parameter int NDIGITS  = 6,
    parameter int PRESCALE = 50000,
    parameter int DEADTIME = 500,
    parameter bit INVERT   = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               S_PSELx,
    input  logic               S_PENABLE,
    input  logic               S_PWRITE,
    input  logic [1:0]         S_PADDR,
    input  logic [15:0]        S_PWDATA,
    output logic [15:0]        S_PRDATA,
    output logic               S_PREADY,
    output logic [6:0]         seg,
    output logic [NDIGITS-1:0] an
);

    localparam int                 CW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]      SHOW_LAST  = CW'(PRESCALE - DEADTIME - 1);
    localparam logic [CW-1:0]      BLANK_LAST = CW'(DEADTIME - 1);
    localparam logic [2:0]         LAST_IDX   = 3'(NDIGITS - 1);
    // "Off" at the pins; XOR with these turns an active-high value into
    // pin polarity.
    localparam logic [6:0]         SEG_OFF    = {7{INVERT}};
    localparam logic [NDIGITS-1:0] AN_OFF     = {NDIGITS{INVERT}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t        state;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;

    logic [15:0]   data_lo;
    logic [7:0]    data_hi;
    logic [5:0]    mask;
    logic          scan_en;

    logic          access;
    logic          wr_en;
    logic [23:0]   nibbles;

    logic [2:0]         nxt_idx;
    logic [3:0]         nxt_nib;
    logic [6:0]         nxt_seg;
    logic [NDIGITS-1:0] nxt_an;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h67;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign access   = S_PSELx & S_PENABLE;
    assign wr_en    = access & S_PWRITE;
    assign S_PREADY = access;
    assign nibbles  = {data_hi, data_lo};

    // ---------------------------------------------------------------- APB
    always_comb begin
        S_PRDATA = '0;
        if (access) begin
            case (S_PADDR)
                2'd0:    S_PRDATA = data_lo;
                2'd1:    S_PRDATA = {8'h00, data_hi};
                2'd2:    S_PRDATA = {7'h00, scan_en, 2'b00, mask};
                default: S_PRDATA = {11'h000, state, idx};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_lo <= '0;
            data_hi <= '0;
            mask    <= '0;
            scan_en <= 1'b0;
        end else if (wr_en) begin
            case (S_PADDR)
                2'd0: data_lo <= S_PWDATA;
                2'd1: data_hi <= S_PWDATA[7:0];
                2'd2: begin
                    mask    <= S_PWDATA[5:0];
                    scan_en <= S_PWDATA[8];
                end
                default: ;  // STATUS is read-only
            endcase
        end
    end

    // ------------------------------------------------------ next slot view
    // Digit index, nibble and mask bit are sampled only when a SHOW slot is
    // entered, so register writes landing mid-slot show up on the next slot.
    always_comb begin
        nxt_idx = '0;
        if (state == BLANK)
            nxt_idx = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
        nxt_nib = nibbles[{nxt_idx, 2'b00} +: 4];
        nxt_seg = hex7(nxt_nib) ^ SEG_OFF;
        nxt_an  = AN_OFF;
        // A masked digit still gets its full slot with an off, keeping duty
        // uniform across digits.
        if (mask[nxt_idx])
            nxt_an = AN_OFF ^ (NDIGITS'(1) << nxt_idx);
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset || !scan_en) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            seg   <= SEG_OFF;
            an    <= AN_OFF;
        end else begin
            case (state)
                IDLE: begin
                    state <= SHOW;
                    idx   <= nxt_idx;
                    cnt   <= '0;
                    seg   <= nxt_seg;
                    an    <= nxt_an;
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state <= BLANK;
                        cnt   <= '0;
                        seg   <= SEG_OFF;
                        an    <= AN_OFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= SHOW;
                        idx   <= nxt_idx;
                        cnt   <= '0;
                        seg   <= nxt_seg;
                        an    <= nxt_an;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    cnt   <= '0;
                    seg   <= SEG_OFF;
                    an    <= AN_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl with PRESCALE=8, DEADTIME=2, INVERT=1.
// Expected pin values are queued per absolute clock number as stimulus is
// issued; a negedge monitor pops and compares them. Read data is queued by
// the read task and compared in the access phase.
module tb_ssd_scan_ctrl;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        S_PSELx   = 1'b0;
    logic        S_PENABLE = 1'b0;
    logic        S_PWRITE  = 1'b0;
    logic [1:0]  S_PADDR   = 2'd0;
    logic [15:0] S_PWDATA  = 16'h0;
    logic [15:0] S_PRDATA;
    logic        S_PREADY;
    logic [6:0]  seg;
    logic [5:0]  an;

    ssd_scan_ctrl #(
        .NDIGITS (6),
        .PRESCALE(8),
        .DEADTIME(2),
        .INVERT  (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .S_PSELx  (S_PSELx),
        .S_PENABLE(S_PENABLE),
        .S_PWRITE (S_PWRITE),
        .S_PADDR  (S_PADDR),
        .S_PWDATA (S_PWDATA),
        .S_PRDATA (S_PRDATA),
        .S_PREADY (S_PREADY),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [5:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t        sq[$];
    logic [15:0] rq[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Segment table {g..a}, active high.
    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: dec = 7'b0111111;  4'h1: dec = 7'b0000110;
            4'h2: dec = 7'b1011011;  4'h3: dec = 7'b1001111;
            4'h4: dec = 7'b1100110;  4'h5: dec = 7'b1101101;
            4'h6: dec = 7'b1111101;  4'h7: dec = 7'b0000111;
            4'h8: dec = 7'b1111111;  4'h9: dec = 7'b1100111;
            4'hA: dec = 7'b1110111;  4'hB: dec = 7'b1111100;
            4'hC: dec = 7'b0111001;  4'hD: dec = 7'b1011110;
            4'hE: dec = 7'b1111001;  default: dec = 7'b1110001;
        endcase
    endfunction

    task automatic push_show(input int t, input int k, input bit on, input logic [3:0] nib, input int n);
        exp_t       e;
        logic [5:0] one = 6'b1;
        for (int i = 0; i < n; i++) begin
            e.cyc = t + i;
            e.an  = on ? ~(one << k) : 6'h3F;
            e.seg = ~dec(nib);
            sq.push_back(e);
        end
    endtask

    task automatic push_off(input int t0, input int t1);
        exp_t e;
        for (int t = t0; t <= t1; t++) begin
            e.cyc = t;
            e.an  = 6'h3F;
            e.seg = 7'h7F;
            sq.push_back(e);
        end
    endtask

    // n consecutive 8-clock slots starting at digit 'first', clock t.
    task automatic push_slots(input int t, input int first, input int n, input logic [23:0] d, input logic [5:0] m);
        for (int s = 0; s < n; s++) begin
            int k = (first + s) % 6;
            push_show(t + 8 * s, k, m[k], d[4 * k +: 4], 6);
            push_off(t + 8 * s + 6, t + 8 * s + 7);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            e = sq.pop_front();
            if (e.cyc < cyc) begin
                chk($sformatf("slot_missed@%0d", e.cyc), cyc, e.cyc);
            end else begin
                chk($sformatf("an@%0d", e.cyc), an, e.an);
                chk($sformatf("seg@%0d", e.cyc), seg, e.seg);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        tick();
        S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWRITE = 1'b1; S_PADDR = a; S_PWDATA = d;
        tick();
        S_PENABLE = 1'b1;
        tick();  // commit edge
        S_PSELx = 1'b0; S_PENABLE = 1'b0; S_PWRITE = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] e, input string tag);
        rq.push_back(e);
        tick();
        S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWRITE = 1'b0; S_PADDR = a;
        #1;
        chk({tag, "_ready_setup"}, S_PREADY, 1'b0);
        chk({tag, "_prdata_setup"}, S_PRDATA, 16'h0);
        tick();
        S_PENABLE = 1'b1;
        #1;
        chk({tag, "_ready_access"}, S_PREADY, 1'b1);
        chk(tag, S_PRDATA, rq.pop_front());
        tick();
        S_PSELx = 1'b0; S_PENABLE = 1'b0;
        #1;
        chk({tag, "_ready_idle"}, S_PREADY, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b;

        // Reset state, then idle
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_an", an, 6'h3F);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_prdata", S_PRDATA, 16'h0);
        chk("rst_pready", S_PREADY, 1'b0);
        b = cyc;
        push_off(b + 1, b + 20);
        repeat (20) tick();
        rd(2'd3, 16'h0000, "status_idle");
        rd(2'd2, 16'h0000, "ctrl_idle");

        // Full scan, two frames
        wr(2'd0, 16'h3210);
        wr(2'd1, 16'h0054);
        wr(2'd2, 16'h013F);
        b = cyc;
        push_off(b, b);
        push_slots(b + 1, 0, 12, 24'h543210, 6'h3F);
        repeat (93) tick();

        // Sparse mask, DATA_LO rewritten during digit 1 SHOW
        wr(2'd2, 16'h0105);  // commits on last BLANK clock of frame 2
        b = cyc;
        push_slots(b + 1, 0, 2, 24'h543210, 6'h05);
        push_slots(b + 17, 2, 4, 24'h540F00, 6'h05);
        repeat (7) tick();
        wr(2'd0, 16'h0F00);  // commits at b+10, mid digit-1 SHOW
        repeat (35) tick();
        wr(2'd2, 16'h013F);  // commits on last clock of this frame

        // Disable during BLANK of digit 3
        b = cyc;
        push_slots(b + 1, 0, 3, 24'h540F00, 6'h3F);
        push_show(b + 25, 3, 1'b1, 4'h0, 6);
        push_off(b + 31, b + 38);
        repeat (26) tick();
        rd(2'd3, 16'h000B, "status_show3");  // SHOW, idx 3
        wr(2'd2, 16'h0000);                  // commits at b+32 (BLANK)
        rd(2'd3, 16'h0000, "status_disabled");
        wr(2'd2, 16'h013F);                  // re-enable, commits at b+38

        // Restart at digit 0, readback, reset mid-SHOW
        b = cyc;
        push_off(b, b);
        push_slots(b + 1, 0, 3, 24'h540F00, 6'h3F);
        push_show(b + 25, 3, 1'b1, 4'h0, 1);
        push_off(b + 26, b + 45);
        rd(2'd0, 16'h0F00, "rd_data_lo");
        rd(2'd1, 16'h0054, "rd_data_hi");
        rd(2'd3, 16'h0010, "status_blank0");  // BLANK, idx 0
        wr(2'd3, 16'hFFFF);                   // ignored
        rd(2'd3, 16'h0009, "status_show1");   // SHOW, idx 1
        wr(2'd2, 16'hFFFF);
        rd(2'd2, 16'h013F, "rd_ctrl_reserved");
        repeat (4) tick();
        reset = 1'b1;
        tick();  // reset sampled at b+26, digit 3 lit since b+25
        reset = 1'b0;
        rd(2'd0, 16'h0000, "post_rst_data_lo");
        rd(2'd1, 16'h0000, "post_rst_data_hi");
        rd(2'd2, 16'h0000, "post_rst_ctrl");
        rd(2'd3, 16'h0000, "post_rst_status");

        for (int i = 0; i < 100 && sq.size() > 0; i++) tick();
        chk("scoreboard_drained", sq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
